// File: rtl/mod_swapchain_pkg.sv
// mod_swapchain_pkg: shared types for the modulation segment swap chain.
//   mod_settings_t     - settings bundle from the controller (UPDATE qualifies the rest)
//   transition_mode_t  - swap trigger source codes
//   REP_INFINITE       - repeat count meaning "play forever"
//   is_immediate()     - any unknown mode code behaves as IMMEDIATE
package mod_swapchain_pkg;

  localparam int unsigned MS_IDX_W      = 15;
  localparam int unsigned MS_SYS_TIME_W = 57;
  localparam int unsigned MS_REP_W      = 16;
  localparam int unsigned MS_MODE_W     = 8;
  localparam int unsigned MS_VALUE_W    = 64;

  localparam logic [MS_REP_W-1:0] REP_INFINITE = 16'hFFFF;

  typedef enum logic [MS_MODE_W-1:0] {
    TM_SYNC_IDX  = 8'h00,
    TM_SYS_TIME  = 8'h01,
    TM_GPIO      = 8'h02,
    TM_EXT       = 8'hF0,
    TM_IMMEDIATE = 8'hFF
  } transition_mode_t;

  typedef struct packed {
    logic                              UPDATE;
    logic                              REQ_RD_SEGMENT;
    logic [MS_MODE_W-1:0]              TRANSITION_MODE;
    logic [MS_VALUE_W-1:0]             TRANSITION_VALUE;
    logic [1:0][MS_IDX_W-1:0]          CYCLE;
    logic [1:0][MS_REP_W-1:0]          REP;
  } mod_settings_t;

  // Unknown mode codes fall back to an immediate swap.
  function automatic logic is_immediate(input logic [MS_MODE_W-1:0] mode);
    return !((mode == TM_SYNC_IDX) || (mode == TM_SYS_TIME) ||
             (mode == TM_GPIO)     || (mode == TM_EXT));
  endfunction

endpackage

// File: rtl/mod_swapchain.sv
// mod_swapchain: selects which modulation segment (0/1) is played, times
// requested segment swaps to a trigger source, and stops finite repeats.
//   CLK, RESETN   - clock, synchronous active-low reset
//   MOD_SETTINGS  - settings bundle, latched on UPDATE
//   SYS_TIME      - synchronised system time (SYS_TIME trigger)
//   IDX           - current sample index of each segment
//   GPIO_IN       - synchronised external triggers (GPIO trigger)
//   SEGMENT       - segment being read
//   STOP          - finite repetition finished, index holds
//   SWAPPED       - 1-cycle pulse when SEGMENT changes
module mod_swapchain
  import mod_swapchain_pkg::*;
#(
  parameter int unsigned IDX_W      = MS_IDX_W,
  parameter int unsigned SYS_TIME_W = MS_SYS_TIME_W
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  mod_settings_t           MOD_SETTINGS,
  input  logic [SYS_TIME_W-1:0]   SYS_TIME,
  input  logic [1:0][IDX_W-1:0]   IDX,
  input  logic [3:0]              GPIO_IN,
  output logic                    SEGMENT,
  output logic                    STOP,
  output logic                    SWAPPED
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_SWAP, ST_HALT} state_t;

  state_t                     state_q, state_d;
  logic                       req_seg_q;
  logic [MS_MODE_W-1:0]       mode_q;
  logic [SYS_TIME_W-1:0]      value_q;
  logic [1:0][MS_REP_W-1:0]   rep_q;
  logic [1:0][IDX_W-1:0]      cycle_q;
  logic [1:0][IDX_W-1:0]      idx_q;
  logic [3:0]                 gpio_q;
  logic [MS_REP_W-1:0]        loop_cnt_q, loop_cnt_d;
  logic                       segment_d, stop_d, swapped_d;

  logic [1:0]                 wrap;
  logic                       cur_wrap, finite, limit, mode_ext, gpio_edge;
  logic                       trigger, target, do_swap;

  // Only the low SYS_TIME_W bits of the transition value are meaningful.
  logic unused_value_hi;
  assign unused_value_hi = ^MOD_SETTINGS.TRANSITION_VALUE[MS_VALUE_W-1:SYS_TIME_W];

  // Wrap of each segment: index went from CYCLE back to 0.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      wrap[s] = (idx_q[s] == cycle_q[s]) && (IDX[s] == '0);
    end
  end

  assign cur_wrap  = wrap[SEGMENT];
  assign finite    = (rep_q[SEGMENT] != REP_INFINITE);
  assign limit     = cur_wrap && finite && (loop_cnt_q == rep_q[SEGMENT]);
  assign mode_ext  = (mode_q == TM_EXT);
  assign gpio_edge = GPIO_IN[value_q[1:0]] & ~gpio_q[value_q[1:0]];
  assign target    = mode_ext ? ~SEGMENT : req_seg_q;

  // Trigger for the latched transition mode.
  always_comb begin
    case (mode_q)
      TM_SYNC_IDX: trigger = cur_wrap;
      TM_SYS_TIME: trigger = (SYS_TIME >= value_q);
      TM_GPIO:     trigger = gpio_edge;
      TM_EXT:      trigger = limit;
      default:     trigger = 1'b1;
    endcase
  end

  // Next-state and registered-output logic; UPDATE overrides any other event.
  always_comb begin
    state_d    = state_q;
    segment_d  = SEGMENT;
    stop_d     = STOP;
    swapped_d  = 1'b0;
    loop_cnt_d = loop_cnt_q;
    do_swap    = 1'b0;
    if (MOD_SETTINGS.UPDATE) begin
      loop_cnt_d = '0;
      if (MOD_SETTINGS.REQ_RD_SEGMENT == SEGMENT) begin
        state_d = ST_RUN;
        stop_d  = 1'b0;
      end else if (is_immediate(MOD_SETTINGS.TRANSITION_MODE)) begin
        state_d = ST_SWAP;
      end else begin
        state_d = ST_WAIT;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (limit) begin
            if (mode_ext) begin
              do_swap = 1'b1;
            end else begin
              state_d = ST_HALT;
              stop_d  = 1'b1;
            end
          end else if (cur_wrap && finite) begin
            loop_cnt_d = loop_cnt_q + 16'd1;
          end
        end
        ST_WAIT: begin
          if (trigger) begin
            do_swap = 1'b1;
          end else if (limit) begin
            state_d = ST_HALT;
            stop_d  = 1'b1;
          end else if (cur_wrap && finite) begin
            loop_cnt_d = loop_cnt_q + 16'd1;
          end
        end
        ST_SWAP: do_swap = 1'b1;
        ST_HALT: ;
      endcase
    end
    if (do_swap) begin
      state_d    = ST_RUN;
      segment_d  = target;
      swapped_d  = 1'b1;
      stop_d     = 1'b0;
      loop_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q    <= ST_RUN;
      SEGMENT    <= 1'b0;
      STOP       <= 1'b0;
      SWAPPED    <= 1'b0;
      loop_cnt_q <= '0;
      req_seg_q  <= 1'b0;
      mode_q     <= '0;
      value_q    <= '0;
      rep_q      <= {REP_INFINITE, REP_INFINITE};
      cycle_q    <= '0;
      idx_q      <= '0;
      gpio_q     <= '0;
    end else begin
      state_q    <= state_d;
      SEGMENT    <= segment_d;
      STOP       <= stop_d;
      SWAPPED    <= swapped_d;
      loop_cnt_q <= loop_cnt_d;
      idx_q      <= IDX;
      gpio_q     <= GPIO_IN;
      if (MOD_SETTINGS.UPDATE) begin
        req_seg_q <= MOD_SETTINGS.REQ_RD_SEGMENT;
        mode_q    <= MOD_SETTINGS.TRANSITION_MODE;
        value_q   <= MOD_SETTINGS.TRANSITION_VALUE[SYS_TIME_W-1:0];
        rep_q     <= MOD_SETTINGS.REP;
        cycle_q   <= MOD_SETTINGS.CYCLE;
      end
    end
  end

endmodule

// File: tb/tb_mod_swapchain.sv
// tb_mod_swapchain: directed bench for mod_swapchain. A behavioural model
// (pending request / plays-completed bookkeeping) is compared every cycle,
// and directed steps pin key moments with literal expectations.
module tb_mod_swapchain;
  import mod_swapchain_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  mod_settings_t     ms;
  logic [56:0]       sys_time;
  logic [1:0][14:0]  idx;
  logic [3:0]        gpio;
  logic              seg, stop, swp;

  mod_swapchain dut (
    .CLK(clk), .RESETN(rst_n), .MOD_SETTINGS(ms), .SYS_TIME(sys_time),
    .IDX(idx), .GPIO_IN(gpio), .SEGMENT(seg), .STOP(stop), .SWAPPED(swp)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  bit               m_seg, m_stop, m_swp, m_pend, m_imm, m_halt;
  mod_settings_t    m_lat;
  int               m_plays;
  logic [1:0][14:0] m_prev_idx;
  logic [3:0]       m_prev_gpio;

  task automatic model_step();
    bit wr, finite, done, trig, known;
    logic [7:0] md;
    if (!rst_n) begin
      m_seg = 0; m_stop = 0; m_swp = 0; m_pend = 0; m_imm = 0; m_halt = 0;
      m_lat = '0; m_lat.REP = {16'hFFFF, 16'hFFFF};
      m_plays = 0; m_prev_idx = '0; m_prev_gpio = '0;
      return;
    end
    wr     = (m_prev_idx[m_seg] == m_lat.CYCLE[m_seg]) && (idx[m_seg] == 15'd0);
    finite = (m_lat.REP[m_seg] != 16'hFFFF);
    done   = wr && finite && (m_plays == int'(m_lat.REP[m_seg]));
    md     = m_lat.TRANSITION_MODE;
    case (md)
      8'h00:   trig = wr;
      8'h01:   trig = (sys_time >= m_lat.TRANSITION_VALUE[56:0]);
      8'h02:   trig = gpio[m_lat.TRANSITION_VALUE[1:0]] && !m_prev_gpio[m_lat.TRANSITION_VALUE[1:0]];
      8'hF0:   trig = done;
      default: trig = 1'b1;
    endcase
    m_swp = 0;
    if (ms.UPDATE) begin
      m_lat = ms; m_plays = 0; m_halt = 0;
      known = (ms.TRANSITION_MODE == 8'h00) || (ms.TRANSITION_MODE == 8'h01) ||
              (ms.TRANSITION_MODE == 8'h02) || (ms.TRANSITION_MODE == 8'hF0);
      if (ms.REQ_RD_SEGMENT == m_seg) begin
        m_stop = 0; m_pend = 0; m_imm = 0;
      end else if (!known) begin
        m_imm = 1; m_pend = 0;
      end else begin
        m_pend = 1; m_imm = 0;
      end
    end else if (m_imm) begin
      m_seg = m_lat.REQ_RD_SEGMENT; m_swp = 1; m_stop = 0; m_plays = 0; m_imm = 0;
    end else if (!m_halt) begin
      if (md == 8'hF0 && done) begin
        m_seg = ~m_seg; m_swp = 1; m_stop = 0; m_plays = 0; m_pend = 0;
      end else if (m_pend && trig) begin
        m_seg = m_lat.REQ_RD_SEGMENT; m_swp = 1; m_stop = 0; m_plays = 0; m_pend = 0;
      end else if (done) begin
        m_stop = 1; m_halt = 1; m_pend = 0;
      end else if (wr && finite) begin
        m_plays++;
      end
    end
    m_prev_idx  = idx;
    m_prev_gpio = gpio;
  endtask

  // Per-cycle comparison against the model, sampled after the edge.
  always @(posedge clk) begin
    model_step();
    #1;
    chk("cyc_segment", 32'(seg), 32'(m_seg));
    chk("cyc_stop", 32'(stop), 32'(m_stop));
    chk("cyc_swapped", 32'(swp), 32'(m_swp));
  end

  // Drive one UPDATE strobe (called on a falling edge, returns one cycle later).
  task automatic send(input bit req, input logic [7:0] mode, input logic [63:0] val,
                      input logic [15:0] r0, input logic [15:0] r1);
    ms.UPDATE           = 1'b1;
    ms.REQ_RD_SEGMENT   = req;
    ms.TRANSITION_MODE  = mode;
    ms.TRANSITION_VALUE = val;
    ms.CYCLE[0]         = 15'd3;
    ms.CYCLE[1]         = 15'd3;
    ms.REP[0]           = r0;
    ms.REP[1]           = r1;
    @(negedge clk);
    ms.UPDATE = 1'b0;
  endtask

  initial begin
    int flip_t, stop_k, swaps;
    rst_n = 1'b0; ms = '0; sys_time = '0; idx = '0; gpio = '0;

    // Reset
    repeat (5) @(negedge clk);
    chk("rst_segment", 32'(seg), 32'd0);
    chk("rst_stop", 32'(stop), 32'd0);
    chk("rst_swapped", 32'(swp), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // IMMEDIATE: change visible two cycles after UPDATE
    send(1'b1, 8'hFF, 64'd0, 16'hFFFF, 16'hFFFF);
    chk("imm_t1_segment", 32'(seg), 32'd0);
    chk("imm_t1_swapped", 32'(swp), 32'd0);
    @(negedge clk);
    chk("imm_t2_segment", 32'(seg), 32'd1);
    chk("imm_t2_swapped", 32'(swp), 32'd1);
    @(negedge clk);
    chk("imm_t3_swapped", 32'(swp), 32'd0);

    // SYS_TIME: flip right after 1000 is sampled
    sys_time = 57'd990;
    send(1'b0, 8'h01, 64'd1000, 16'hFFFF, 16'hFFFF);
    chk("st_wait_segment", 32'(seg), 32'd1);
    flip_t = -1;
    for (int t = 991; t <= 1010; t++) begin
      sys_time = 57'(t);
      @(negedge clk);
      if (flip_t < 0 && seg == 1'b0) flip_t = t;
    end
    chk("st_flip_time", 32'(flip_t), 32'd1000);
    sys_time = '0;

    // Finite repeat: REP=1, CYCLE=3 -> STOP after the second wrap
    send(1'b0, 8'h00, 64'd0, 16'd1, 16'hFFFF);
    stop_k = -1;
    for (int k = 0; k <= 8; k++) begin
      idx[0] = 15'(k % 4);
      @(negedge clk);
      if (stop_k < 0 && stop) stop_k = k;
    end
    chk("rep_stop_cycle", 32'(stop_k), 32'd8);
    repeat (3) @(negedge clk);
    chk("rep_stop_held", 32'(stop), 32'd1);
    chk("rep_segment", 32'(seg), 32'd0);
    send(1'b0, 8'h00, 64'd0, 16'd1, 16'hFFFF);
    chk("rep_stop_cleared", 32'(stop), 32'd0);

    // EXT: toggle after every wrap
    send(1'b0, 8'hF0, 64'd0, 16'd0, 16'd0);
    swaps = 0;
    for (int k = 0; k <= 12; k++) begin
      idx[0] = 15'(k % 4);
      idx[1] = 15'(k % 4);
      @(negedge clk);
      if (swp) swaps++;
      chk("ext_swapped", 32'(swp), 32'((k % 4 == 0) && (k > 0)));
      if (k == 4)  chk("ext_seg_k4", 32'(seg), 32'd1);
      if (k == 8)  chk("ext_seg_k8", 32'(seg), 32'd0);
      if (k == 12) chk("ext_seg_k12", 32'(seg), 32'd1);
    end
    chk("ext_swap_count", 32'(swaps), 32'd3);

    // Collision: same-segment UPDATE with a GPIO edge while waiting
    send(1'b0, 8'h02, 64'd1, 16'hFFFF, 16'hFFFF);
    chk("col_wait_segment", 32'(seg), 32'd1);
    gpio = 4'b0010;
    send(1'b1, 8'h02, 64'd1, 16'hFFFF, 16'hFFFF);
    for (int k = 0; k < 3; k++) begin
      chk("col_segment", 32'(seg), 32'd1);
      chk("col_swapped", 32'(swp), 32'd0);
      @(negedge clk);
    end

    // GPIO edge swaps one cycle after it is seen
    gpio = 4'b0000;
    send(1'b0, 8'h02, 64'd1, 16'hFFFF, 16'hFFFF);
    chk("gpio_wait_segment", 32'(seg), 32'd1);
    gpio = 4'b0010;
    @(negedge clk);
    chk("gpio_segment", 32'(seg), 32'd0);
    chk("gpio_swapped", 32'(swp), 32'd1);

    // Unknown mode code behaves as IMMEDIATE
    send(1'b1, 8'h55, 64'd0, 16'hFFFF, 16'hFFFF);
    chk("unk_t1_segment", 32'(seg), 32'd0);
    @(negedge clk);
    chk("unk_t2_segment", 32'(seg), 32'd1);
    chk("unk_t2_swapped", 32'(swp), 32'd1);

    // Reset mid-operation, GPIO pin held high across it
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_segment", 32'(seg), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send(1'b1, 8'h02, 64'd1, 16'hFFFF, 16'hFFFF);
    repeat (3) @(negedge clk);
    chk("hold_high_no_swap", 32'(seg), 32'd0);

    // SYS_TIME already past on entry: swap on the first WAIT cycle
    sys_time = 57'd2000;
    send(1'b1, 8'h01, 64'd1000, 16'hFFFF, 16'hFFFF);
    chk("past_t1_segment", 32'(seg), 32'd0);
    @(negedge clk);
    chk("past_t2_segment", 32'(seg), 32'd1);
    chk("past_t2_swapped", 32'(swp), 32'd1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
